gf180mcu_fd_sc_mcu9t5v0__demux2_reg: RTL and testbench

//   Registered 1-to-2 demultiplexer with valid/ready handshake on every port.

---
 rtl/gf180mcu_fd_sc_mcu9t5v0__demux2_reg.sv | 91 +++++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0__demux2_reg.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__demux2_reg.sv
// Registered 1-to-2 demultiplexer with a valid/ready handshake on every port.
// Optional per-output delivery counters under `DEMUX2_CNT_EN`; power pins under `USE_POWER_PINS`.
module gf180mcu_fd_sc_mcu9t5v0__demux2_reg #(
  parameter int WIDTH = 1,
  parameter int CNTW  = 8
) (
`ifdef USE_POWER_PINS
  inout  wire              VDD,
  inout  wire              VSS,
`endif
  input  logic             CLK,
  input  logic             RN,
  input  logic [WIDTH-1:0] I,
  input  logic             S,
  input  logic             IV,
  output logic             IR,
  output logic [WIDTH-1:0] Z0,
  output logic             Z0V,
  input  logic             Z0R,
  output logic [WIDTH-1:0] Z1,
  output logic             Z1V,
  input  logic             Z1R
`ifdef DEMUX2_CNT_EN
  ,
  output logic [CNTW-1:0]  CNT0,
  output logic [CNTW-1:0]  CNT1
`endif
);

  logic [WIDTH-1:0] r_z0, r_z1;
  logic             r_z0v, r_z1v;
  logic             w_rdy0, w_rdy1;
  logic             w_ld0, w_ld1;
  logic             w_dr0, w_dr1;

  // A slot can take a word when it is empty, or when it drains on this same edge.
  assign w_rdy0 = !r_z0v | Z0R;
  assign w_rdy1 = !r_z1v | Z1R;
  assign IR     = S ? w_rdy1 : w_rdy0;

  assign w_ld0  = IV & IR & (S == 1'b0);
  assign w_ld1  = IV & IR & (S == 1'b1);
  assign w_dr0  = r_z0v & Z0R;
  assign w_dr1  = r_z1v & Z1R;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_z0  <= '0;
      r_z1  <= '0;
      r_z0v <= 1'b0;
      r_z1v <= 1'b0;
    end else begin
      if (w_ld0) begin
        r_z0  <= I;
        r_z0v <= 1'b1;
      end else if (w_dr0) begin
        r_z0v <= 1'b0;
      end
      if (w_ld1) begin
        r_z1  <= I;
        r_z1v <= 1'b1;
      end else if (w_dr1) begin
        r_z1v <= 1'b0;
      end
    end
  end

  assign Z0  = r_z0;
  assign Z1  = r_z1;
  assign Z0V = r_z0v;
  assign Z1V = r_z1v;

`ifdef DEMUX2_CNT_EN
  logic [CNTW-1:0] r_cnt0, r_cnt1;

  // Counters stick at all-ones instead of wrapping.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_dr0 && (r_cnt0 != '1)) r_cnt0 <= r_cnt0 + 1'b1;
      if (w_dr1 && (r_cnt1 != '1)) r_cnt1 <= r_cnt1 + 1'b1;
    end
  end

  assign CNT0 = r_cnt0;
  assign CNT1 = r_cnt1;
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__demux2_reg.sv
// Directed bench for the registered demux2, with a queue-based reference model
// checked every cycle plus literal expectations.
module tb_gf180mcu_fd_sc_mcu9t5v0__demux2_reg;
  localparam int WIDTH = 4;
  localparam int CNTW  = 2;
  localparam int MAXC  = 3;

  logic             CLK = 1'b0;
  logic             RN  = 1'b0;
  logic [WIDTH-1:0] I   = '0;
  logic             S   = 1'b0;
  logic             IV  = 1'b0;
  logic             IR;
  logic [WIDTH-1:0] Z0, Z1;
  logic             Z0V, Z1V;
  logic             Z0R = 1'b0;
  logic             Z1R = 1'b0;
`ifdef DEMUX2_CNT_EN
  logic [CNTW-1:0]  CNT0, CNT1;
`endif

  gf180mcu_fd_sc_mcu9t5v0__demux2_reg #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .CLK(CLK), .RN(RN), .I(I), .S(S), .IV(IV), .IR(IR),
    .Z0(Z0), .Z0V(Z0V), .Z0R(Z0R),
    .Z1(Z1), .Z1V(Z1V), .Z1R(Z1R)
`ifdef DEMUX2_CNT_EN
    , .CNT0(CNT0), .CNT1(CNT1)
`endif
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each output is a queue of at most one pending word.
  logic [WIDTH-1:0] q0[$], q1[$];
  logic [WIDTH-1:0] last0, last1;
  int               n0, n1;
  logic [WIDTH-1:0] got0[$], got1[$];

  function automatic logic m_ir();
    if (S) return (q1.size() == 0) || Z1R;
    return (q0.size() == 0) || Z0R;
  endfunction

  always @(posedge CLK or negedge RN) begin
    if (!RN) begin
      q0.delete(); q1.delete();
      last0 = '0; last1 = '0;
      n0 = 0; n1 = 0;
    end else begin
      logic acc;
      acc = IV && m_ir();
      if (q0.size() != 0 && Z0R) begin got0.push_back(q0.pop_front()); n0++; end
      if (q1.size() != 0 && Z1R) begin got1.push_back(q1.pop_front()); n1++; end
      if (acc) begin
        if (S) begin q1.push_back(I); last1 = I; end
        else   begin q0.push_back(I); last0 = I; end
      end
    end
  end

  bit cmp_en = 1'b0;
  always @(negedge CLK) begin
    if (cmp_en && RN) begin
      chk("m_ir",  {31'd0, IR},  {31'd0, m_ir()});
      chk("m_z0v", {31'd0, Z0V}, {31'd0, q0.size() != 0});
      chk("m_z1v", {31'd0, Z1V}, {31'd0, q1.size() != 0});
      chk("m_z0",  32'(Z0), 32'(last0));
      chk("m_z1",  32'(Z1), 32'(last1));
`ifdef DEMUX2_CNT_EN
      chk("m_cnt0", 32'(CNT0), (n0 > MAXC) ? MAXC : n0);
      chk("m_cnt1", 32'(CNT1), (n1 > MAXC) ? MAXC : n1);
`endif
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #3;
    chk("rst_z0v", {31'd0, Z0V}, 32'd0);
    chk("rst_z1v", {31'd0, Z1V}, 32'd0);
    chk("rst_z0",  32'(Z0), 32'd0);
    chk("rst_z1",  32'(Z1), 32'd0);
    step();
    RN = 1'b1;
    cmp_en = 1'b1;

    // Route
    I = 4'hA; S = 1'b0; IV = 1'b1; Z0R = 1'b0; Z1R = 1'b0;
    step();
    chk("route_z0",  32'(Z0), 32'hA);
    chk("route_z0v", {31'd0, Z0V}, 32'd1);
    chk("route_z1v", {31'd0, Z1V}, 32'd0);
    I = 4'h5; S = 1'b1;
    step();
    chk("route_z1",  32'(Z1), 32'h5);
    chk("route_z1v", {31'd0, Z1V}, 32'd1);
    chk("route_hold_z0", 32'(Z0), 32'hA);

    // Backpressure
    I = 4'h3; S = 1'b0;
    #1;
    chk("bp_ir0", {31'd0, IR}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_hold_z0", 32'(Z0), 32'hA);
      chk("bp_ir_low", {31'd0, IR}, 32'd0);
    end
    Z0R = 1'b1;
    #1;
    chk("bp_ir1", {31'd0, IR}, 32'd1);
    step();
    chk("bp_new_z0", 32'(Z0), 32'h3);
    chk("bp_z0v", {31'd0, Z0V}, 32'd1);

    // Streaming
    for (int w = 1; w <= 8; w++) begin
      I = WIDTH'(w);
      #1;
      chk("stream_ir", {31'd0, IR}, 32'd1);
      step();
      chk("stream_z0", 32'(Z0), w);
      chk("stream_z0v", {31'd0, Z0V}, 32'd1);
    end
    IV = 1'b0;
    step();
    chk("stream_drained", {31'd0, Z0V}, 32'd0);

    // Split: alternating select, both consumers ready
    got0.delete(); got1.delete();
    Z1R = 1'b1; IV = 1'b1;
    for (int k = 0; k < 8; k++) begin
      S = k[0];
      I = WIDTH'(8 + k);
      step();
      if (k[0]) begin
        chk("split_z1", 32'(Z1), 8 + k);
        chk("split_z1v", {31'd0, Z1V}, 32'd1);
        chk("split_z0v", {31'd0, Z0V}, 32'd0);
      end else begin
        chk("split_z0", 32'(Z0), 8 + k);
        chk("split_z0v", {31'd0, Z0V}, 32'd1);
        chk("split_z1v", {31'd0, Z1V}, 32'd0);
      end
    end
    IV = 1'b0;
    step();
    step();
    // got1 also holds the stale 5 from Route, drained on the first split edge
    chk("split_n0", got0.size(), 4);
    chk("split_n1", got1.size(), 5);
    for (int k = 0; k < 4; k++) begin
      if (k < got0.size()) chk("split_seq0", 32'(got0[k]), 8 + 2 * k);
      if (k + 1 < got1.size()) chk("split_seq1", 32'(got1[k + 1]), 9 + 2 * k);
    end

    // Reset mid-run with both slots full
    Z0R = 1'b0; Z1R = 1'b0; IV = 1'b1;
    S = 1'b0; I = 4'h6; step();
    S = 1'b1; I = 4'h7; step();
    IV = 1'b0;
    chk("pre_rst_z0v", {31'd0, Z0V}, 32'd1);
    chk("pre_rst_z1v", {31'd0, Z1V}, 32'd1);
    #1;
    RN = 1'b0;
    #1;
    chk("arst_z0v", {31'd0, Z0V}, 32'd0);
    chk("arst_z1v", {31'd0, Z1V}, 32'd0);
    chk("arst_z0",  32'(Z0), 32'd0);
    chk("arst_z1",  32'(Z1), 32'd0);
    step();
    RN = 1'b1;

`ifdef DEMUX2_CNT_EN
    // Counters: five drains on Z1 saturate a 2-bit counter
    Z1R = 1'b1; S = 1'b1; IV = 1'b1;
    for (int k = 0; k < 5; k++) begin
      I = WIDTH'(k + 1);
      step();
    end
    IV = 1'b0;
    step();
    chk("cnt1_sat", 32'(CNT1), 32'd3);
    chk("cnt0_zero", 32'(CNT0), 32'd0);
    #1;
    RN = 1'b0;
    #1;
    chk("cnt1_rst", 32'(CNT1), 32'd0);
    chk("cnt0_rst", 32'(CNT0), 32'd0);
    step();
    RN = 1'b1;
`endif

    step();
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
